// File: rtl/rotate_pkg.sv
// Shared types and defaults for the sequential rotate engine.
package rotate_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
      DONE = 2'd2
   } rot_state_t;

   localparam int ROT_WIDTH = 4;

endpackage

// File: rtl/rotate_step.sv
// Single-position rotate stage; en=0 passes the word through unchanged.
// With ROTATE_SEQUENCER_LEFT_EN defined a left input selects the direction.
module rotate_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] d_in,
   input  logic             en,
`ifdef ROTATE_SEQUENCER_LEFT_EN
   input  logic             left,
`endif
   output logic [WIDTH-1:0] d_out
);

   logic [WIDTH-1:0] rot_r;
   logic [WIDTH-1:0] rot_l;

   assign rot_r = {d_in[0], d_in[WIDTH-1:1]};
   assign rot_l = {d_in[WIDTH-2:0], d_in[WIDTH-1]};

`ifdef ROTATE_SEQUENCER_LEFT_EN
   assign d_out = !en ? d_in : (left ? rot_l : rot_r);
`else
   assign d_out = en ? rot_r : d_in;
`endif

endmodule

// File: rtl/rotate_sequencer.sv
// Rotates a word one position per clock for 'amount' steps, then holds the result.
// Macro ROTATE_SEQUENCER_LEFT_EN adds a dir port (1 = left rotate).
module rotate_sequencer
   import rotate_pkg::*;
#(
   parameter int WIDTH = ROT_WIDTH,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amount,
`ifdef ROTATE_SEQUENCER_LEFT_EN
   input  logic             dir,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_ROT  = ROT;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       state;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] step_out;

`ifdef ROTATE_SEQUENCER_LEFT_EN
   logic dir_q;
`endif

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state == S_ROT);
   assign out_valid = (state == S_DONE);
   assign data_out  = data_q;

   rotate_step #(.WIDTH(WIDTH)) u_step (
      .d_in  (data_q),
      .en    (busy),
`ifdef ROTATE_SEQUENCER_LEFT_EN
      .left  (dir_q),
`endif
      .d_out (step_out)
   );

`ifdef ROTATE_SEQUENCER_LEFT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dir_q <= 1'b0;
      else if (state == S_IDLE && in_valid)
         dir_q <= dir;
   end
`endif

   // ROT is only entered with a nonzero count, so cnt never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         data_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  data_q <= data_in;
                  cnt    <= amount;
                  state  <= (amount != '0) ? S_ROT : S_DONE;
               end
            end
            S_ROT: begin
               data_q <= step_out;
               cnt    <= cnt - AMT_W'(1);
               if (cnt == AMT_W'(1))
                  state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
